// File: rtl/pc_unit.sv
// Program counter with stall, jump-register and exception redirect, and a
// circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_sig,
  input  logic [15:0]       branch_in,
  input  logic              jump_sig,
  input  logic [25:0]       jump_in,
  input  logic              jr_sig,
  input  logic [ADDR_W-1:0] jr_in,
  input  logic              call_sig,
  input  logic              ret_sig,
  input  logic              exc_sig,
  output logic [ADDR_W-1:0] out,
  output logic [ADDR_W-1:0] link_out,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_EXC   = 3'd0,
    SRC_STALL = 3'd1,
    SRC_RET   = 3'd2,
    SRC_JR    = 3'd3,
    SRC_BR    = 3'd4,
    SRC_JMP   = 3'd5,
    SRC_SEQ   = 3'd6
  } src_e;

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] sext_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] ras_r [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  top_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              ras_empty_r;
  logic              ras_full_r;
  logic              push_s;
  logic              pop_s;
  src_e              src_s;

  // ptr_r names the next free slot; the top of stack sits one below it.
  assign pc4_s     = pc_r + ADDR_W'(32'd4);
  assign sext_s    = {{(ADDR_W-16){branch_in[15]}}, branch_in};
  assign top_s     = ptr_r - PTR_W'(1'b1);
  assign out       = pc_r;
  assign link_out  = pc_r + ADDR_W'(32'd8);
  assign ras_empty = ras_empty_r;
  assign ras_full  = ras_full_r;

  // Pick the single next-PC source by fixed priority.
  always_comb begin
    src_s = SRC_SEQ;
    if (exc_sig) begin
      src_s = SRC_EXC;
    end else if (stall) begin
      src_s = SRC_STALL;
    end else if (ret_sig) begin
      src_s = SRC_RET;
    end else if (jr_sig) begin
      src_s = SRC_JR;
    end else if (branch_sig) begin
      src_s = SRC_BR;
    end else if (jump_sig) begin
      src_s = SRC_JMP;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Next PC and RAS push/pop for the selected source.
  always_comb begin
    next_pc_s = pc4_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    case (src_s)
      SRC_EXC:   next_pc_s = EXC_VEC;
      SRC_STALL: next_pc_s = pc_r;
      SRC_RET: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          next_pc_s = ras_r[top_s];
          pop_s     = 1'b1;
        end else begin
          next_pc_s = jr_in;
        end
      end
      SRC_JR: begin
        next_pc_s = {jr_in[ADDR_W-1:2], 2'b00};
        push_s    = call_sig;
      end
      SRC_BR:    next_pc_s = pc4_s + {sext_s[ADDR_W-3:0], 2'b00};
      SRC_JMP: begin
        next_pc_s = {pc4_s[ADDR_W-1:28], jump_in, 2'b00};
        push_s    = call_sig;
      end
      SRC_SEQ:   next_pc_s = pc4_s;
      default:   next_pc_s = EXC_VEC;
    endcase
  end

  // Occupancy update; a push into a full stack keeps the count saturated.
  always_comb begin
    cnt_next_s = cnt_r;
    if (pop_s) begin
      cnt_next_s = cnt_r - CNT_W'(1'b1);
    end else if (push_s && (cnt_r != DEPTH_C)) begin
      cnt_next_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // PC, stack pointer, count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= RESET_VEC;
      ptr_r       <= {PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      pc_r        <= next_pc_s;
      cnt_r       <= cnt_next_s;
      ras_empty_r <= (cnt_next_s == {CNT_W{1'b0}});
      ras_full_r  <= (cnt_next_s == DEPTH_C);
      if (push_s) begin
        ptr_r <= ptr_r + PTR_W'(1'b1);
      end else if (pop_s) begin
        ptr_r <= top_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Stack storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_r[ptr_r] <= link_out;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts each
// cycle's outputs, and a monitor compares them one cycle after issue.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_sig, jump_sig, jr_sig, call_sig, ret_sig, exc_sig;
  logic [15:0] branch_in;
  logic [25:0] jump_in;
  logic [31:0] jr_in;
  logic [31:0] out_s, link_s;
  logic        empty_s, full_s;

  pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h0000_0080), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_sig(branch_sig), .branch_in(branch_in),
    .jump_sig(jump_sig), .jump_in(jump_in),
    .jr_sig(jr_sig), .jr_in(jr_in),
    .call_sig(call_sig), .ret_sig(ret_sig), .exc_sig(exc_sig),
    .out(out_s), .link_out(link_s), .ras_empty(empty_s), .ras_full(full_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] link;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          step_id = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; branch_sig = 1'b0; jump_sig = 1'b0; jr_sig = 1'b0;
    call_sig = 1'b0; ret_sig = 1'b0; exc_sig = 1'b0;
    branch_in = 16'h0; jump_in = 26'h0; jr_in = 32'h0;
  endtask

  task automatic model_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) m_ras.delete(0);
  endtask

  // Reference: plain arithmetic on the PC and a queue for the stack.
  task automatic model_step();
    logic [31:0] pc4;
    logic [31:0] link;
    int          off;
    pc4  = m_pc + 32'd4;
    link = m_pc + 32'd8;
    off  = int'($signed(branch_in));
    if (exc_sig) m_pc = 32'h80;
    else if (stall) m_pc = m_pc;
    else if (ret_sig) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = jr_in;
    end else if (jr_sig) begin
      if (call_sig) model_push(link);
      m_pc = jr_in & ~32'd3;
    end else if (branch_sig) m_pc = pc4 + 32'(off * 4);
    else if (jump_sig) begin
      if (call_sig) model_push(link);
      m_pc = {pc4[31:28], jump_in, 2'b00};
    end else m_pc = pc4;
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.id    = step_id;
    e.pc    = m_pc;
    e.link  = m_pc + 32'd8;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    sb_q.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk($sformatf("out[%0d]", mon_e.id), out_s, mon_e.pc);
      chk($sformatf("link_out[%0d]", mon_e.id), link_s, mon_e.link);
      chk($sformatf("ras_empty[%0d]", mon_e.id), {31'd0, empty_s}, {31'd0, mon_e.empty});
      chk($sformatf("ras_full[%0d]", mon_e.id), {31'd0, full_s}, {31'd0, mon_e.full});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    m_pc  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", out_s, 32'h0);
    chk("reset_empty", {31'd0, empty_s}, 32'd1);
    chk("reset_full", {31'd0, full_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) begin idle(); step(); end

    idle(); jr_sig = 1'b1; jr_in = 32'h100; step();
    idle(); branch_sig = 1'b1; branch_in = 16'hFFFE; step();
    idle(); jr_sig = 1'b1; jr_in = 32'h100; step();
    idle(); branch_sig = 1'b1; branch_in = 16'h0003; step();

    idle(); jr_sig = 1'b1; jr_in = 32'h3000_0010; step();
    idle(); jump_sig = 1'b1; jump_in = 26'h000_0040; step();
    idle(); jr_sig = 1'b1; jr_in = 32'h2003; step();

    repeat (2) begin idle(); stall = 1'b1; branch_sig = 1'b1; branch_in = 16'h0010; step(); end
    idle(); stall = 1'b1; exc_sig = 1'b1; step();

    idle(); jr_sig = 1'b1; jr_in = 32'h10; step();
    for (int k = 1; k <= 5; k++) begin
      idle(); jump_sig = 1'b1; call_sig = 1'b1; jump_in = 26'((k + 1) * 4); step();
    end
    repeat (4) begin idle(); ret_sig = 1'b1; step(); end
    idle(); ret_sig = 1'b1; jr_in = 32'h900; step();

    for (int i = 0; i < 400; i++) begin
      idle();
      exc_sig    = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      ret_sig    = ($urandom_range(0, 4) == 0);
      jr_sig     = ($urandom_range(0, 4) == 0);
      branch_sig = ($urandom_range(0, 3) == 0);
      jump_sig   = ($urandom_range(0, 2) == 0);
      call_sig   = ($urandom_range(0, 1) == 1);
      branch_in  = 16'($urandom);
      jump_in    = 26'($urandom);
      jr_in      = $urandom;
      step();
    end

    idle(); jump_sig = 1'b1; call_sig = 1'b1; jump_in = 26'h100; step();
    idle(); jr_sig = 1'b1; call_sig = 1'b1; jr_in = 32'h4000; step();
    idle(); branch_sig = 1'b1; branch_in = 16'h0020;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_s, 32'h0);
    chk("async_rst_empty", {31'd0, empty_s}, 32'd1);
    chk("async_rst_full", {31'd0, full_s}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_out", out_s, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 32'h0;
    m_ras.delete();
    repeat (2) begin idle(); step(); end

    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the MIPS-style CPU; drives the instruction-fetch address.
- Adds to the basic PC:
  - asynchronous active-low reset to a configurable vector
  - fetch stall
  - jump-register redirect
  - exception redirect
  - a small circular return-address stack (RAS) for call/return
  - a link-address output
- Branch and jump target arithmetic is unchanged from the existing PC (MIPS semantics).

Parameters:
- ADDR_W, 32, PC width in bits; legal values >= 32.
- RESET_VEC, 0, PC value loaded on reset (word aligned).
- EXC_VEC, 32'h0000_0080, exception handler address.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC; the RAS is also frozen.
- branch_sig  input  1  take PC-relative branch.
- branch_in  input  16  signed word offset.
- jump_sig  input  1  take region jump.
- jump_in  input  26  jump word index.
- jr_sig  input  1  jump to register value.
- jr_in  input  ADDR_W  register target.
- call_sig  input  1  push link address onto RAS (qualifies jump_sig/jr_sig).
- ret_sig  input  1  return: pop RAS, redirect to popped address.
- exc_sig  input  1  exception redirect.
- out  output  ADDR_W  current PC.
- link_out  output  ADDR_W  out + 8 (link value for jal/jalr).
- ras_empty  output  1  RAS holds no valid entry.
- ras_full  output  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out=RESET_VEC, RAS pointer=0, count=0.
  - ras_empty=1, ras_full=0. RAS contents are don't-care.
  - Release is synchronous to clk; the first update occurs at the first posedge with rst_n=1.
- Definitions:
  - pc4 = out + 4.
  - sext = {{(ADDR_W-16){branch_in[15]}}, branch_in}.
- Next-PC priority, evaluated each posedge; exactly one source applies:
  1. exc_sig: next = EXC_VEC. Overrides stall. No RAS action.
  2. stall: next = out. No RAS action.
  3. ret_sig: if count>0, next = RAS[top] and pop. If count==0, next = jr_in and no pop.
  4. jr_sig: next = jr_in & ~3 (low two bits forced 0).
  5. branch_sig: next = pc4 + (sext << 2), modulo 2^ADDR_W (wrap, no trap).
  6. jump_sig: next = {pc4[ADDR_W-1:28], jump_in, 2'b00}.
  7. Otherwise: next = pc4. out = 2^ADDR_W-4 wraps to 0.
- call_sig:
  - Honoured only when selected source is jr_sig or jump_sig.
  - Push link_out (sampled before the update) at the top.
  - Ignored with any other source.
- RAS is circular:
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop decrements count. Push increments count, saturating at RAS_DEPTH.
- ret_sig with call_sig asserted together: pop only; call_sig is ignored.
- Latency: one cycle. out changes only at posedge or asynchronous reset.
- Status outputs:
  - ras_empty/ras_full are registered and reflect post-update count.
  - link_out is combinational from out.
- Reset asserted mid-stream immediately forces the reset state. A pending redirect is discarded.
- No $display in synthesizable paths; bench-side tracing only.

Test Plan:
- Reset RESET_VEC=0: hold rst_n=0, toggle clk -> out=0, ras_empty=1. Release, 3 idle clocks -> out=4, 8, 12.
- Branch at out=0x100, branch_in=16'hFFFE -> out=0xFC. At out=0x100, branch_in=16'h0003 -> out=0x110.
- Jump at out=0x3000_0010, jump_in=26'h000_0040 -> out=0x3000_0100. jr_sig with jr_in=0x2003 -> out=0x2000.
- Stall for 2 cycles with branch_sig=1 -> out unchanged. Assert exc_sig with stall=1 -> out=0x80.
- RAS, RAS_DEPTH=4:
  - 5 calls (jump_sig+call_sig) from out=0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1.
  - 4 returns -> out=0x58, 0x48, 0x38, 0x28; then ras_empty=1.
  - 5th return with jr_in=0x900 -> out=0x900.
- Async reset pulse mid-cycle during a taken branch -> out=RESET_VEC immediately (before next clk), ras_empty=1.
